// File: rtl/gray_decoder.sv
// Synchronises an asynchronous Gray-coded bus, decodes it to binary and classifies each change.
// Optional signed step accumulator on `pos` is built when GRAY_DECODER_POS_EN is defined.
module gray_decoder #(
    parameter int bits        = 8,
    parameter int sync_stages = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [bits-1:0] gray_in,
    input  logic            err_clr,
    output logic [bits-1:0] bin_out,
    output logic            valid,
    output logic            dir,
    output logic            step_err,
    output logic [7:0]      err_count,
    output logic            locked,
    output logic [15:0]     pos
);

    typedef enum logic {
        FILL  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // The reference is captured one cycle after the chain has been filled with post-reset samples.
    localparam logic [2:0]      fill_last = 3'(sync_stages + 1);
    localparam logic [bits-1:0] step_up   = {{(bits-1){1'b0}}, 1'b1};
    localparam logic [bits-1:0] step_dn   = {bits{1'b1}};

    function automatic logic [bits-1:0] gray_to_bin(input logic [bits-1:0] g);
        logic [bits-1:0] b;
        b[bits-1] = g[bits-1];
        for (int i = bits - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [bits-1:0] sync_q [sync_stages];
    logic [bits-1:0] dec;
    logic [bits-1:0] delta;

    state_t          state_q, state_d;
    logic [2:0]      fill_cnt_q, fill_cnt_d;
    logic [bits-1:0] bin_d;
    logic            valid_d, step_err_d, dir_d, locked_d, err_hit;
    logic [7:0]      err_d;
`ifdef GRAY_DECODER_POS_EN
    logic [15:0]     pos_d;
`endif

    // NOTE: the synchroniser array is plain flops, so it is cleared with a loop like any other register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < sync_stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < sync_stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign dec = gray_to_bin(sync_q[sync_stages-1]);

    // NOTE: every value written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        bin_d      = bin_out;
        valid_d    = 1'b0;
        step_err_d = 1'b0;
        dir_d      = dir;
        locked_d   = locked;
        err_hit    = 1'b0;
        err_d      = err_count;
`ifdef GRAY_DECODER_POS_EN
        pos_d      = pos;
`endif
        delta      = dec - bin_out;

        case (state_q)
            FILL: begin
                if (fill_cnt_q == fill_last) begin
                    bin_d    = dec;
                    locked_d = 1'b1;
                    state_d  = TRACK;
                end else begin
                    fill_cnt_d = fill_cnt_q + 3'd1;
                end
            end
            TRACK: begin
                if (delta == step_up) begin
                    bin_d   = dec;
                    valid_d = 1'b1;
                    dir_d   = 1'b1;
`ifdef GRAY_DECODER_POS_EN
                    pos_d   = pos + 16'd1;
`endif
                end else if (delta == step_dn) begin
                    bin_d   = dec;
                    valid_d = 1'b1;
                    dir_d   = 1'b0;
`ifdef GRAY_DECODER_POS_EN
                    pos_d   = pos - 16'd1;
`endif
                end else if (delta != '0) begin
                    bin_d      = dec;
                    step_err_d = 1'b1;
                    err_hit    = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase

        // A clear coinciding with an error keeps that error counted.
        if (err_hit) begin
            err_d = err_clr ? 8'd1 : ((err_count == 8'hFF) ? 8'hFF : err_count + 8'd1);
        end else if (err_clr) begin
            err_d = '0;
        end
    end

    // NOTE: sequential state only ever uses <=, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            bin_out    <= '0;
            valid      <= 1'b0;
            dir        <= 1'b0;
            step_err   <= 1'b0;
            err_count  <= '0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            bin_out    <= bin_d;
            valid      <= valid_d;
            dir        <= dir_d;
            step_err   <= step_err_d;
            err_count  <= err_d;
            locked     <= locked_d;
        end
    end

`ifdef GRAY_DECODER_POS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pos <= '0;
        end else begin
            pos <= pos_d;
        end
    end
`else
    assign pos = '0;
`endif

endmodule

// File: doc/gray_decoder.md
# gray_decoder

Receive-side counterpart of the on-board Gray-code counter. Samples a Gray-coded bus arriving asynchronously (from another clock domain or from header pins driven by a second board), synchronises it, and decodes it to binary. Classifies every change as a legal step up, a legal step down or an illegal multi-bit jump, and reports counts of each. Sits between the `gp`/`gn` header or a CDC boundary and user logic such as LED/OLED diagnostics.

## Interface
- `bits`, 8: width of the Gray bus and of the decoded value; legal range 2..16.
- `sync_stages`, 2: number of synchroniser flops on `gray_in`; legal range 2..4.
- `clk`  in  1  system clock (25 MHz `clk_25mhz` at top level).
- `resetn`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `gray_in`  in  `bits`  asynchronous Gray-coded input.
- `err_clr`  in  1  single-cycle request to zero `err_count`.
- `bin_out`  out  `bits`  decoded binary value of the last accepted sample.
- `valid`  out  1  one-cycle pulse: `bin_out` changed by a legal step.
- `dir`  out  1  direction of the last legal step: 1 = up, 0 = down.
- `step_err`  out  1  one-cycle pulse: illegal jump detected.
- `err_count`  out  8  number of illegal jumps, saturating at 255.
- `locked`  out  1  high once a reference sample has been captured.
- `pos`  out  16  signed step accumulator (see Configuration).

## Operation
- Reset (`resetn`=0 at a rising edge): synchroniser flops, `bin_out`, `valid`, `dir`, `step_err`, `err_count`, `locked`, `pos` all go to 0; FSM enters FILL. Reset mid-operation aborts everything; no pulse is emitted on the cycle reset is sampled.
- FILL: counts `sync_stages` cycles after reset release so the chain holds real samples. Then captures the decoded synchronised value into `bin_out` as the reference, sets `locked`=1 with no `valid`/`step_err`, and enters TRACK.
- TRACK: each cycle, decode synchronised Gray to binary `b` (b[msb]=g[msb]; b[i]=b[i+1]^g[i]). Compute `d = b - bin_out` modulo 2^`bits`.
  - d=0: no action.
  - d=1: `bin_out<=b`, `valid`=1, `dir`=1, `pos`+1.
  - d=2^`bits`-1: `bin_out<=b`, `valid`=1, `dir`=0, `pos`-1.
  - Otherwise: `bin_out<=b` (resynchronise), `step_err`=1, `err_count`+1 saturating; `dir`, `pos` unchanged.
- Wrap-around: max→0 is a legal up step and 0→max a legal down step.
- `pos` wraps two's-complement at ±32768; no saturation.
- `err_clr` with no coincident error: `err_count`<=0. With a coincident error: `err_count`<=1, so the event is not lost.
- `err_count` at 255 stays at 255 on further errors; `step_err` still pulses.
- `valid` and `step_err` are never high together.

## Timing
- Every output is registered. A `gray_in` value stable before rising edge N is reflected on `bin_out`/`valid`/`step_err` after edge N+`sync_stages`; with defaults, after edge N+2.
- `locked` rises after edge R+`sync_stages`+1, where R is the first edge sampling `resetn`=1.
- Sustained input rate: one legal step per `clk` cycle; every step produces exactly one `valid` pulse.
- `err_clr` takes effect on the edge that samples it; `err_count` reads 0 on the next cycle.

## Configuration
- `GRAY_DECODER_POS_EN` defined: 16-bit `pos` accumulator is built and operates as described.
- Not defined: accumulator logic is omitted and `pos` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then hold `gray_in`=8'h00 → `locked` rises at R+3, `bin_out`=0, no `valid`/`step_err` pulses.
- Step Gray sequence 00,01,03,02 one per cycle → three `valid` pulses, `bin_out`=3, `dir`=1, `pos`=3 (with POS_EN), latency 2 cycles per step.
- From binary 0, apply Gray 8'h80 (binary 255) → `valid`, `dir`=0, `pos`=-1; then Gray 8'h00 → `valid`, `dir`=1, `pos`=0 (wrap both ways).
- From binary 3 (Gray 02), jump to Gray 8'h0C (binary 8) → `step_err` pulse, `err_count`=1, `bin_out`=8, `pos` unchanged. Repeat 300 jumps → `err_count`=255.
- Assert `err_clr` on the same cycle as a `step_err` → `err_count`=1. Assert `err_clr` alone → `err_count`=0.
- Pull `resetn` low mid-stream for one cycle → all outputs 0 the next cycle, then FILL/relock sequence repeats.
